// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its hazard unit, CSR unit,
// E-stage redirect source, instruction memory and the decode stage.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    // Control and redirect inputs to the fetch stage
    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            TrapRedirect;
    logic [XLEN-1:0] TrapVector;
    logic            MretRedirect;
    logic [XLEN-1:0] MepcValue;
    logic [31:0]     InstrF;

    // Fetch address and IF/ID register contents.
    // Handshake: the stage never waits on a ready. ValidD=1 marks InstrD/PCD/PCPlus4D
    // as a real fetched instruction, ValidD=0 is a bubble. Decode backpressure is
    // expressed only through StallD, which holds the whole D slot unchanged.
    logic [XLEN-1:0] PCF;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;

    modport master (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE,
        output TrapRedirect, TrapVector, MretRedirect, MepcValue, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD
    );

    modport slave (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE,
        input  TrapRedirect, TrapVector, MretRedirect, MepcValue, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage RV32 pipeline:
// PC register with next-PC selection, and the D-stage instruction slot.
module fetch_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.slave fif
);
    logic [XLEN-1:0] pcReg;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] pcPlus4;
    logic [31:0]     instrReg;
    logic [XLEN-1:0] pcDReg;
    logic [XLEN-1:0] pcPlus4DReg;
    logic            validReg;
    logic            squashD;

    // Wraps modulo 2^XLEN by construction
    assign pcPlus4 = pcReg + XLEN'(4);

    // Trap and mret both discard the instruction currently being fetched
    assign squashD = fif.FlushD | fif.TrapRedirect | fif.MretRedirect;

    always_comb begin
        pcNext = pcPlus4;
        if (fif.TrapRedirect) begin
            pcNext = {fif.TrapVector[XLEN-1:2], 2'b00};
        end else if (fif.MretRedirect) begin
            pcNext = {fif.MepcValue[XLEN-1:2], 2'b00};
        end else if (fif.PCSrcE) begin
            pcNext = {fif.PCTargetE[XLEN-1:2], 2'b00};
        end else if (fif.StallF) begin
            pcNext = pcReg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg <= XLEN'(RESET_PC);
        end else begin
            pcReg <= pcNext;
        end
    end

    // A squashed slot keeps PCD/PCPlus4D so the bubble still carries a sane PC
    always_ff @(posedge clk) begin
        if (rst) begin
            instrReg    <= NOP_INSTR;
            pcDReg      <= '0;
            pcPlus4DReg <= '0;
            validReg    <= 1'b0;
        end else if (squashD) begin
            instrReg <= NOP_INSTR;
            validReg <= 1'b0;
        end else if (!fif.StallD) begin
            instrReg    <= fif.InstrF;
            pcDReg      <= pcReg;
            pcPlus4DReg <= pcPlus4;
            validReg    <= 1'b1;
        end
    end

    assign fif.PCF      = pcReg;
    assign fif.InstrD   = instrReg;
    assign fif.PCD      = pcDReg;
    assign fif.PCPlus4D = pcPlus4DReg;
    assign fif.ValidD   = validReg;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner cases, then
// randomized control traffic checked against a behavioural pipeline model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          OUTW = 32 * 4 + 1;

    logic clk;
    logic rst;
    int   nVectors;
    int   nMiscompares;

    fetch_stage_if #(.XLEN(32)) fif ();

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .fif(fif.slave)
    );

    // Instruction memory content is a fixed hash of the address
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign fif.InstrF = memWord(fif.PCF);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stallF;
        logic        stallD;
        logic        flushD;
        logic        pcSrcE;
        logic [31:0] pcTargetE;
        logic        trap;
        logic [31:0] trapVector;
        logic        mret;
        logic [31:0] mepc;
        logic [31:0] expPCF;
        logic [31:0] expInstrD;
        logic [31:0] expPCD;
        logic [31:0] expPCPlus4D;
        logic        expValidD;
    } vec_t;

    vec_t vecs[$];
    logic [OUTW-1:0] exp_q[$];

    // Behavioural model: architectural PC plus the D slot contents
    logic [31:0] mPC;
    logic [31:0] mInstrD;
    logic [31:0] mPCD;
    logic [31:0] mPCPlus4D;
    logic        mValidD;

    task automatic driveInputs(input vec_t v);
        rst              = v.rst;
        fif.StallF       = v.stallF;
        fif.StallD       = v.stallD;
        fif.FlushD       = v.flushD;
        fif.PCSrcE       = v.pcSrcE;
        fif.PCTargetE    = v.pcTargetE;
        fif.TrapRedirect = v.trap;
        fif.TrapVector   = v.trapVector;
        fif.MretRedirect = v.mret;
        fif.MepcValue    = v.mepc;
    endtask

    task automatic checkOutputs(input string name);
        logic [OUTW-1:0] act;
        logic [OUTW-1:0] exp;
        act = {fif.PCF, fif.InstrD, fif.PCD, fif.PCPlus4D, fif.ValidD};
        if (exp_q.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
            return;
        end
        exp = exp_q.pop_front();
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("FAIL %s: PCF/InstrD/PCD/PCPlus4D/ValidD got %h_%h_%h_%h_%b expected %h_%h_%h_%h_%b",
                     name, act[128:97], act[96:65], act[64:33], act[32:1], act[0],
                     exp[128:97], exp[96:65], exp[64:33], exp[32:1], exp[0]);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled there too
    task automatic applyAndCheck(input vec_t v, input string name);
        driveInputs(v);
        @(posedge clk);
        #1;
        checkOutputs(name);
    endtask

    function automatic vec_t mk(input logic r, input logic sF, input logic sD, input logic fD,
                                input logic br, input logic [31:0] tgt,
                                input logic tr, input logic [31:0] tv,
                                input logic mr, input logic [31:0] mp,
                                input logic [31:0] ePC, input logic [31:0] eI,
                                input logic [31:0] ePCD, input logic [31:0] eP4,
                                input logic eV);
        vec_t v;
        v.rst = r; v.stallF = sF; v.stallD = sD; v.flushD = fD;
        v.pcSrcE = br; v.pcTargetE = tgt; v.trap = tr; v.trapVector = tv;
        v.mret = mr; v.mepc = mp;
        v.expPCF = ePC; v.expInstrD = eI; v.expPCD = ePCD;
        v.expPCPlus4D = eP4; v.expValidD = eV;
        return v;
    endfunction

    // Next state from the rules: reset, then first active redirect, else stall/advance
    task automatic modelStep(input vec_t v);
        logic [31:0] redirects[$];
        logic [31:0] fetchedPC;
        fetchedPC = mPC;
        if (v.rst) begin
            mPC = 32'h0; mInstrD = NOP; mPCD = 0; mPCPlus4D = 0; mValidD = 0;
            return;
        end
        if (v.trap)   redirects.push_back(v.trapVector & ~32'h3);
        if (v.mret)   redirects.push_back(v.mepc & ~32'h3);
        if (v.pcSrcE) redirects.push_back(v.pcTargetE & ~32'h3);
        if (redirects.size() > 0) mPC = redirects[0];
        else if (!v.stallF)       mPC = (fetchedPC + 4) % 64'h1_0000_0000;
        if (v.flushD || v.trap || v.mret) begin
            mInstrD = NOP;
            mValidD = 0;
        end else if (!v.stallD) begin
            mInstrD   = memWord(fetchedPC);
            mPCD      = fetchedPC;
            mPCPlus4D = fetchedPC + 4;
            mValidD   = 1;
        end
    endtask

    initial begin
        vec_t v;
        nVectors = 0;
        nMiscompares = 0;
        v = mk(1,0,0,0, 0,0, 0,0, 0,0, 0,NOP,0,0,0);
        driveInputs(v);
        #1;

        // rst, col: rst sF sD fD | br tgt | tr tv | mr mepc | PCF InstrD PCD PCPlus4D ValidD
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0, 32'h0, NOP, 0, 0, 0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0, 32'h0, NOP, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h4, memWord(32'h0), 32'h0, 32'h4, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h8, memWord(32'h4), 32'h4, 32'h8, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'hC, memWord(32'h8), 32'h8, 32'hC, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h10, memWord(32'hC), 32'hC, 32'h10, 1));
        vecs.push_back(mk(0,1,1,0, 0,0, 0,0, 0,0, 32'h10, memWord(32'hC), 32'hC, 32'h10, 1));
        vecs.push_back(mk(0,1,1,0, 0,0, 0,0, 0,0, 32'h10, memWord(32'hC), 32'hC, 32'h10, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h14, memWord(32'h10), 32'h10, 32'h14, 1));
        vecs.push_back(mk(0,0,0,1, 1,32'h103, 0,0, 0,0, 32'h100, NOP, 32'h10, 32'h14, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h104, memWord(32'h100), 32'h100, 32'h104, 1));
        vecs.push_back(mk(0,1,0,0, 1,32'h300, 1,32'h200, 1,32'h44, 32'h200, NOP, 32'h100, 32'h104, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h204, memWord(32'h200), 32'h200, 32'h204, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 1,32'h46, 32'h44, NOP, 32'h200, 32'h204, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h48, memWord(32'h44), 32'h44, 32'h48, 1));
        vecs.push_back(mk(0,0,1,1, 0,0, 0,0, 0,0, 32'h4C, NOP, 32'h44, 32'h48, 0));
        vecs.push_back(mk(0,0,1,0, 0,0, 0,0, 0,0, 32'h50, NOP, 32'h44, 32'h48, 0));
        vecs.push_back(mk(0,1,0,0, 0,0, 0,0, 0,0, 32'h50, memWord(32'h50), 32'h50, 32'h54, 1));
        vecs.push_back(mk(0,0,0,0, 1,32'hFFFF_FFFE, 0,0, 0,0, 32'hFFFF_FFFC, memWord(32'h50), 32'h50, 32'h54, 1));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1));
        vecs.push_back(mk(1,1,0,0, 0,0, 1,32'h200, 0,0, 32'h0, NOP, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h4, memWord(32'h0), 32'h0, 32'h4, 1));

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].expPCF, vecs[i].expInstrD, vecs[i].expPCD,
                             vecs[i].expPCPlus4D, vecs[i].expValidD});
            applyAndCheck(vecs[i], $sformatf("directed[%0d]", i));
        end

        // Hand-written sequence: two-cycle reset mid-redirect, then model takes over
        mPC = 32'h4; mInstrD = memWord(32'h0); mPCD = 0; mPCPlus4D = 4; mValidD = 1;
        for (int k = 0; k < 2; k++) begin
            v = mk(1,1,1,0, 1,32'h880, 0,0, 1,32'h990, 0,0,0,0,0);
            modelStep(v);
            exp_q.push_back({mPC, mInstrD, mPCD, mPCPlus4D, mValidD});
            applyAndCheck(v, "reset_mid_redirect");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            v = mk(($urandom_range(0, 39) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), $urandom(),
                   ($urandom_range(0, 11) == 0), $urandom(),
                   ($urandom_range(0, 11) == 0), $urandom(),
                   0,0,0,0,0);
            if ($urandom_range(0, 15) == 0) v.pcTargetE = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            modelStep(v);
            exp_q.push_back({mPC, mInstrD, mPCD, mPCPlus4D, mValidD});
            applyAndCheck(v, $sformatf("random[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
